// File: rtl/matrix_scroller_pkg.sv
// matrix_scroller_pkg
//   Shared matrix geometry, column/display types and the display-to-row
//   mapping used by the scroller (and by the row-scanning multiplexer).
//   No ports.
package matrix_scroller_pkg;

    localparam int unsigned MATRIX_ROWS = 5;
    localparam int unsigned MATRIX_COLS = 5;

    // One display column: bit r = LED in row r (1 = lit).
    typedef logic [MATRIX_ROWS-1:0] col_t;

    localparam col_t MATRIX_BLANK_COL = '0;

    // Display register: element 0 is the leftmost column.
    typedef col_t [MATRIX_COLS-1:0] disp_t;

    // Row pattern for row r: leftmost column lands in the MSB.
    function automatic col_t disp_row(input disp_t d, input int unsigned r);
        col_t row;
        row = '0;
        for (int unsigned c = 0; c < MATRIX_COLS; c++) begin
            row[MATRIX_COLS-1-c] = d[c][r];
        end
        return row;
    endfunction

endpackage

// File: rtl/matrix_col_fifo.sv
// matrix_col_fifo
//   Synchronous column-word FIFO with occupancy count.
//   Ports:
//     clk_i    clock (rising edge)
//     rst_ni   asynchronous active-low reset; empties the FIFO
//     push_i   write data_i (ignored when full)
//     data_i   word to write
//     pop_i    drop head word (ignored when empty)
//     data_o   current head word (valid when not empty)
//     full_o   no free slot
//     empty_o  no stored word
//     count_o  number of stored words
module matrix_col_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/matrix_scroller.sv
// matrix_scroller
//   Horizontally scrolling content source for the 5x5 LED matrix.
//   Column words are queued in a FIFO and shifted into the right edge of
//   the display register once every STEP_DIV enabled cycles.
//   Ports:
//     PIXEL_CLK    clock (rising edge)
//     RST_N        asynchronous active-low reset
//     I_enable     scroll enable; low freezes display and clears divider
//     I_col        column word (bit r = row r)
//     I_col_valid  I_col holds a word to push
//     O_col_ready  FIFO can accept a word this cycle
//     row0..row4   row patterns, bit 4 = leftmost column
//     O_step       one-cycle pulse after each display shift
//     O_empty      FIFO holds no words
module matrix_scroller
    import matrix_scroller_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 25000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       PIXEL_CLK,
    input  logic       RST_N,
    input  logic       I_enable,
    input  logic [4:0] I_col,
    input  logic       I_col_valid,
    output logic       O_col_ready,
    output logic [4:0] row0,
    output logic [4:0] row1,
    output logic [4:0] row2,
    output logic [4:0] row3,
    output logic [4:0] row4,
    output logic       O_step,
    output logic       O_empty
);

    localparam logic [31:0] STEP_LAST = 32'(STEP_DIV - 1);

    logic [31:0]              div_q, div_d;
    disp_t                    disp_q, disp_d;
    logic                     step_q;
    logic                     step_now;

    col_t                     fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    matrix_col_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MATRIX_ROWS)
    ) u_fifo (
        .clk_i   (PIXEL_CLK),
        .rst_ni  (RST_N),
        .push_i  (I_col_valid),
        .data_i  (I_col),
        .pop_i   (step_now),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Push is gated inside the FIFO by full, so ready only depends on occupancy.
    assign O_col_ready = !fifo_full;
    assign O_empty     = (fifo_count == '0);

    assign step_now = I_enable && (div_q == STEP_LAST);

    always_comb begin
        div_d = div_q;
        if (!I_enable || step_now) div_d = '0;
        else                       div_d = div_q + 32'd1;
    end

    // Head is sampled from pre-edge occupancy: a word pushed on the step
    // edge itself is not bypassed and waits for the next step.
    always_comb begin
        disp_d = disp_q;
        if (step_now) begin
            for (int unsigned c = 0; c < MATRIX_COLS - 1; c++) begin
                disp_d[c] = disp_q[c+1];
            end
            disp_d[MATRIX_COLS-1] = fifo_empty ? MATRIX_BLANK_COL : fifo_head;
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            disp_q <= '0;
            step_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            disp_q <= disp_d;
            step_q <= step_now;
        end
    end

    assign O_step = step_q;
    assign row0   = disp_row(disp_q, 0);
    assign row1   = disp_row(disp_q, 1);
    assign row2   = disp_row(disp_q, 2);
    assign row3   = disp_row(disp_q, 3);
    assign row4   = disp_row(disp_q, 4);

endmodule

// File: tb/tb_matrix_scroller.sv
// tb_matrix_scroller
//   Directed bench for matrix_scroller with STEP_DIV=4, FIFO_DEPTH=8.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_matrix_scroller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] col = '0;
    logic       col_valid = 1'b0;
    logic       col_ready;
    logic [4:0] r0, r1, r2, r3, r4;
    logic       step;
    logic       empty;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [4:0] words [5];

    always #5 clk = ~clk;

    matrix_scroller #(
        .STEP_DIV   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .PIXEL_CLK   (clk),
        .RST_N       (rst_n),
        .I_enable    (enable),
        .I_col       (col),
        .I_col_valid (col_valid),
        .O_col_ready (col_ready),
        .row0        (r0),
        .row1        (r1),
        .row2        (r2),
        .row3        (r3),
        .row4        (r4),
        .O_step      (step),
        .O_empty     (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        words[0] = 5'b10001;
        words[1] = 5'b01010;
        words[2] = 5'b00100;
        words[3] = 5'b11000;
        words[4] = 5'b00011;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        check("rst_row0", 32'(r0), 32'b0);
        check("rst_row4", 32'(r4), 32'b0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ready", 32'(col_ready), 32'd1);
        check("rst_step", 32'(step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two words, then scroll
        col_valid = 1'b1; col = 5'b11111;
        tick(1);
        col = 5'b00001;
        tick(1);
        col_valid = 1'b0;
        check("two_not_empty", 32'(empty), 32'd0);
        enable = 1'b1;
        tick(3);
        check("s1_early_step", 32'(step), 32'd0);
        check("s1_early_row0", 32'(r0), 32'b0);
        tick(1);
        check("s1_step", 32'(step), 32'd1);
        check("s1_row0", 32'(r0), 32'b00001);
        check("s1_row2", 32'(r2), 32'b00001);
        check("s1_row4", 32'(r4), 32'b00001);
        tick(1);
        check("s1_pulse_one", 32'(step), 32'd0);
        tick(3);
        check("s2_step", 32'(step), 32'd1);
        check("s2_row0", 32'(r0), 32'b00011);
        check("s2_row1", 32'(r1), 32'b00010);
        check("s2_row4", 32'(r4), 32'b00010);
        check("s2_empty", 32'(empty), 32'd1);

        // Reset mid-count with FIFO partly filled
        col_valid = 1'b1; col = 5'b01110;
        tick(2);
        col_valid = 1'b0;
        check("mid_not_empty", 32'(empty), 32'd0);
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_row0", 32'(r0), 32'b0);
        check("mid_rst_row1", 32'(r1), 32'b0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ready", 32'(col_ready), 32'd1);
        check("mid_rst_step", 32'(step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five words, ten steps
        for (int i = 0; i < 5; i++) begin
            col_valid = 1'b1; col = words[i];
            tick(1);
        end
        col_valid = 1'b0;
        enable = 1'b1;
        tick(20);
        check("f5_step", 32'(step), 32'd1);
        check("f5_row0", 32'(r0), 32'b10001);
        check("f5_row2", 32'(r2), 32'b00100);
        check("f5_row4", 32'(r4), 32'b10010);
        check("f5_empty", 32'(empty), 32'd1);
        tick(4);
        check("f6_row0", 32'(r0), 32'b00010);
        check("f6_row4", 32'(r4), 32'b00100);
        tick(16);
        check("f10_step", 32'(step), 32'd1);
        check("f10_row0", 32'(r0), 32'b0);
        check("f10_row1", 32'(r1), 32'b0);
        check("f10_row3", 32'(r3), 32'b0);
        check("f10_row4", 32'(r4), 32'b0);
        check("f10_empty", 32'(empty), 32'd1);

        // Fill to full while disabled
        enable = 1'b0;
        col_valid = 1'b1; col = 5'b00111;
        tick(7);
        check("fill7_ready", 32'(col_ready), 32'd1);
        tick(1);
        check("fill8_ready", 32'(col_ready), 32'd0);
        check("fill8_empty", 32'(empty), 32'd0);
        tick(3);
        check("full_hold_ready", 32'(col_ready), 32'd0);
        enable = 1'b1;
        tick(3);
        check("full_pre_step_ready", 32'(col_ready), 32'd0);
        check("full_pre_step", 32'(step), 32'd0);
        tick(1);
        check("full_step", 32'(step), 32'd1);
        check("full_step_ready", 32'(col_ready), 32'd1);
        check("full_step_row0", 32'(r0), 32'b00001);
        tick(1);
        check("full_refill_ready", 32'(col_ready), 32'd0);
        col_valid = 1'b0;
        enable = 1'b0;

        // Clear out, then push on the exact step edge
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        check("e_rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        enable = 1'b1;
        tick(3);
        col_valid = 1'b1; col = 5'b10101;
        tick(1);
        col_valid = 1'b0;
        check("edge_step", 32'(step), 32'd1);
        check("edge_row0_blank", 32'(r0), 32'b0);
        check("edge_row2_blank", 32'(r2), 32'b0);
        check("edge_stored", 32'(empty), 32'd0);
        tick(4);
        check("edge_next_step", 32'(step), 32'd1);
        check("edge_row0", 32'(r0), 32'b00001);
        check("edge_row1", 32'(r1), 32'b00000);
        check("edge_row2", 32'(r2), 32'b00001);
        check("edge_row4", 32'(r4), 32'b00001);
        check("edge_empty", 32'(empty), 32'd1);

        // Drop enable at divider count 2
        tick(2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("dis_no_step", 32'(step), 32'd0);
        end
        check("dis_row0_held", 32'(r0), 32'b00001);
        enable = 1'b1;
        tick(3);
        check("reen_no_step", 32'(step), 32'd0);
        check("reen_row0_held", 32'(r0), 32'b00001);
        tick(1);
        check("reen_step", 32'(step), 32'd1);
        check("reen_row0", 32'(r0), 32'b00010);
        check("reen_row2", 32'(r2), 32'b00010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
